// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and sizing helpers for the reset sequencer
//   state_t    - sequencer FSM states
//   idx_width  - channel index width for a given channel count, minimum 1
//   IDX_W      - index width for the default 4-channel build
package reset_seq_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, STAG} state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int N_CH_DEF = 4;
    localparam int IDX_W = idx_width(N_CH_DEF);
endpackage

// File: rtl/seq_timer.sv
// seq_timer: up-counter with clear/enable and a terminal match against a limit
//   clk, rst - clock, synchronous active-high reset
//   clr      - zero the counter (wins over en)
//   en       - count this cycle
//   limit    - cycles per phase, must be >= 1
//   match    - high on the last cycle of the phase (count == limit-1)
module seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             match
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + CNT_W'(1);
    end
    assign match = (cnt == limit - CNT_W'(1));
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: masked multi-channel reset pulse with staggered release
//   start     - latch pulse_len/stagger/ch_mask and (re)start a sequence
//   abort     - release every line at once, no done
//   hold      - freeze timing while busy
//   pulse_len - low time of channel 0 (0 treated as 1)
//   stagger   - cycles between consecutive channel releases
//   ch_mask   - channels that participate
//   rst_n_out - active-low reset lines
//   busy      - sequence in progress
//   done      - one-cycle strobe on normal completion
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] stagger,
    input  logic [N_CH-1:0]  ch_mask,
    output logic [N_CH-1:0]  rst_n_out,
    output logic             busy,
    output logic             done
);
    localparam int K_W = idx_width(N_CH);
    state_t           state, state_d;
    logic [K_W-1:0]   k, k_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic             busy_d, done_d;
    logic             pend, pend_d;
    logic [CNT_W-1:0] l_q, s_q;
    logic             load, clr, match;
    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (busy && !hold),
        .limit (state == STAG ? s_q : l_q),
        .match (match)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            out_q <= '1;
            busy  <= 1'b0;
            done  <= 1'b0;
            pend  <= 1'b0;
            l_q   <= CNT_W'(1);
            s_q   <= '0;
        end else begin
            state <= state_d;
            k     <= k_d;
            out_q <= out_d;
            busy  <= busy_d;
            done  <= done_d;
            pend  <= pend_d;
            if (load) begin
                l_q <= (pulse_len == '0) ? CNT_W'(1) : pulse_len;
                s_q <= stagger;
            end
        end
    end
    // pend carries an empty-mask start over to a done strobe one edge later
    always_comb begin
        state_d = state;
        k_d     = k;
        out_d   = out_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pend_d  = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            k_d     = '0;
            out_d   = '1;
            busy_d  = 1'b0;
            clr     = 1'b1;
        end else if (start) begin
            load    = 1'b1;
            clr     = 1'b1;
            k_d     = '0;
            state_d = (ch_mask != '0) ? PULSE : IDLE;
            out_d   = ~ch_mask;
            busy_d  = (ch_mask != '0);
            pend_d  = (ch_mask == '0);
        end else if (pend) begin
            done_d = 1'b1;
        end else if (busy && !hold && match) begin
            if (state == PULSE) begin
                out_d[0] = 1'b1;
                clr      = 1'b1;
                k_d      = K_W'(1);
                state_d  = STAG;
                // zero stagger releases every remaining channel on this edge
                if (N_CH == 1 || s_q == '0) begin
                    out_d   = '1;
                    k_d     = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                out_d[k] = 1'b1;
                clr      = 1'b1;
                k_d      = k + K_W'(1);
                if (k == K_W'(N_CH - 1)) begin
                    out_d   = '1;
                    k_d     = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end
    end
    assign rst_n_out = out_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of the reset sequencer
module tb_reset_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hold = 1'b0;
    logic [23:0] pulse_len = '0;
    logic [23:0] stagger = '0;
    logic [3:0]  ch_mask = '0;
    logic [3:0]  rst_n_out;
    logic        busy, done;
    int vectors = 0;
    int miscompares = 0;
    int t = 0;
    reset_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .pulse_len (pulse_len),
        .stagger   (stagger),
        .ch_mask   (ch_mask),
        .rst_n_out (rst_n_out),
        .busy      (busy),
        .done      (done)
    );
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
        t++;
    endtask
    task automatic go(input int n);
        while (t < n) step();
    endtask
    task automatic fire(input logic [23:0] l, input logic [23:0] s, input logic [3:0] m);
        pulse_len = l;
        stagger   = s;
        ch_mask   = m;
        start     = 1'b1;
        step();
        start     = 1'b0;
        t         = 0;
        pulse_len = 24'd100;
        stagger   = 24'd50;
        ch_mask   = 4'b0000;
    endtask
    task automatic chk(input string tag, input logic [3:0] lines, input logic b, input logic d);
        vectors++;
        assert ({rst_n_out, busy, done} === {lines, b, d})
        else begin
            miscompares++;
            $error("FAIL %s: observed lines=%b busy=%b done=%b, expected lines=%b busy=%b done=%b",
                   tag, rst_n_out, busy, done, lines, b, d);
        end
    endtask
    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("reset", 4'b1111, 1'b0, 1'b0);
        fire(24'd5, 24'd3, 4'b1111);
        chk("basic_T", 4'b0000, 1'b1, 1'b0);
        go(4);  chk("basic_T4", 4'b0000, 1'b1, 1'b0);
        go(5);  chk("basic_T5", 4'b0001, 1'b1, 1'b0);
        go(7);  chk("basic_T7", 4'b0001, 1'b1, 1'b0);
        go(8);  chk("basic_T8", 4'b0011, 1'b1, 1'b0);
        go(11); chk("basic_T11", 4'b0111, 1'b1, 1'b0);
        go(13); chk("basic_T13", 4'b0111, 1'b1, 1'b0);
        go(14); chk("basic_T14", 4'b1111, 1'b0, 1'b1);
        go(15); chk("basic_T15", 4'b1111, 1'b0, 1'b0);
        fire(24'd0, 24'd0, 4'b0101);
        chk("mask_T", 4'b1010, 1'b1, 1'b0);
        go(1);  chk("mask_T1", 4'b1111, 1'b0, 1'b1);
        go(2);  chk("mask_T2", 4'b1111, 1'b0, 1'b0);
        fire(24'd5, 24'd3, 4'b1111);
        go(2);
        hold = 1'b1;
        go(5);  chk("hold_T5", 4'b0000, 1'b1, 1'b0);
        go(6);
        hold = 1'b0;
        go(8);  chk("hold_T8", 4'b0000, 1'b1, 1'b0);
        go(9);  chk("hold_T9", 4'b0001, 1'b1, 1'b0);
        go(12); chk("hold_T12", 4'b0011, 1'b1, 1'b0);
        go(17); chk("hold_T17", 4'b0111, 1'b1, 1'b0);
        go(18); chk("hold_T18", 4'b1111, 1'b0, 1'b1);
        fire(24'd5, 24'd3, 4'b1111);
        go(9);  chk("abort_T9", 4'b0011, 1'b1, 1'b0);
        abort = 1'b1;
        hold  = 1'b1;
        go(10); chk("abort_T10", 4'b1111, 1'b0, 1'b0);
        abort = 1'b0;
        hold  = 1'b0;
        go(14); chk("abort_T14", 4'b1111, 1'b0, 1'b0);
        fire(24'd5, 24'd3, 4'b1111);
        go(5);  chk("after_abort_T5", 4'b0001, 1'b1, 1'b0);
        go(14); chk("after_abort_T14", 4'b1111, 1'b0, 1'b1);
        fire(24'd5, 24'd3, 4'b1111);
        go(8);  chk("retrig_T8", 4'b0011, 1'b1, 1'b0);
        fire(24'd5, 24'd3, 4'b1111);
        chk("retrig_T9", 4'b0000, 1'b1, 1'b0);
        go(4);  chk("retrig_T13", 4'b0000, 1'b1, 1'b0);
        go(5);  chk("retrig_T14", 4'b0001, 1'b1, 1'b0);
        go(13); chk("retrig_T22", 4'b0111, 1'b1, 1'b0);
        go(14); chk("retrig_T23", 4'b1111, 1'b0, 1'b1);
        go(15); chk("retrig_T24", 4'b1111, 1'b0, 1'b0);
        abort = 1'b1;
        fire(24'd5, 24'd3, 4'b1111);
        abort = 1'b0;
        chk("start_abort", 4'b1111, 1'b0, 1'b0);
        go(5);  chk("start_abort_T5", 4'b1111, 1'b0, 1'b0);
        fire(24'd5, 24'd3, 4'b1111);
        go(6);  chk("rst_T6", 4'b0001, 1'b1, 1'b0);
        rst = 1'b1;
        go(7);  chk("rst_T7", 4'b1111, 1'b0, 1'b0);
        rst = 1'b0;
        go(8);
        fire(24'd5, 24'd3, 4'b0000);
        chk("empty_T", 4'b1111, 1'b0, 1'b0);
        go(1);  chk("empty_T1", 4'b1111, 1'b0, 1'b1);
        go(2);  chk("empty_T2", 4'b1111, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
